wb_protocol_monitor: RTL and testbench

- Parametrised, synthesizable Wishbone B4 pipelined-mode protocol monitor. Taps a master/slave link passively and never drives the bus.
- Tracks outstanding transactions, enforces STALL-hold rules, detects orphan ACKs, outstanding-depth overflow, ACK timeouts and aborted cycles.
- Reports violations as registered sticky flags plus counters. Usable in simulation benches and as an on-chip debug block.

---
 rtl/wb_protocol_monitor.sv | 167 ++++++++++++++++
 tb/tb_wb_protocol_monitor.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_protocol_monitor.sv
// Passive Wishbone B4 pipelined-mode protocol monitor: tracks outstanding requests
// and reports protocol violations as sticky flags, a first-error index and counters.
module wb_protocol_monitor #(
   parameter int unsigned ADR_WIDTH       = 32,
   parameter int unsigned DAT_WIDTH       = 32,
   parameter int unsigned SEL_WIDTH       = DAT_WIDTH / 8,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned ACK_TIMEOUT     = 16,
   parameter int unsigned CNT_WIDTH       = 16,
   parameter int unsigned ALLOW_MIXED     = 1
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       clear,
   input  logic                                       cyc,
   input  logic                                       stb,
   input  logic                                       we,
   input  logic [ADR_WIDTH-1:0]                       adr,
   input  logic [SEL_WIDTH-1:0]                       sel,
   input  logic [DAT_WIDTH-1:0]                       dat_m,
   input  logic                                       ack,
   input  logic                                       err,
   input  logic                                       stall,
   output logic [7:0]                                 err_flags,
   output logic                                       err_pulse,
   output logic [2:0]                                 err_first,
   output logic                                       err_valid,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding,
   output logic [CNT_WIDTH-1:0]                       req_cnt,
   output logic [CNT_WIDTH-1:0]                       rsp_cnt
);

   localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [OUT_W-1:0]     OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
   localparam logic [TMR_W-1:0]     TMR_MAX  = TMR_W'(ACK_TIMEOUT);
   localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

   logic                 accept;
   logic                 resp;
   logic [7:0]           viol;
   logic [7:0]           new_flags;
   logic [2:0]           first_idx;
   logic [OUT_W-1:0]     out_next;
   logic [TMR_W-1:0]     timer_next;

   logic [TMR_W-1:0]     timer_q;
   logic                 cyc_q;
   logic                 hold_q;
   logic [ADR_WIDTH-1:0] adr_q;
   logic                 we_q;
   logic [SEL_WIDTH-1:0] sel_q;
   logic [DAT_WIDTH-1:0] dat_q;
   logic                 have_we_q;
   logic                 first_we_q;

   assign accept = cyc & stb & ~stall;
   assign resp   = cyc & (ack | err);

   // Violation detection for the current cycle
   always_comb begin
      viol = '0;
`ifdef SYNTHESIS
      viol[0] = 1'b0;
`else
      viol[0] = ((cyc === 1'b1) && $isunknown({stb, stall, ack, err})) ||
                ((stb === 1'b1) && $isunknown({adr, we, sel}));
`endif
      viol[1] = hold_q & (~cyc | ~stb | (adr != adr_q) | (we != we_q) |
                          (sel != sel_q) | (we & (dat_m != dat_q)));
      viol[2] = resp & (outstanding == '0);
      viol[3] = accept & ~resp & (outstanding == OUT_MAX);
      // Fires only on the step into saturation, so once per stalled episode
      viol[4] = ~resp & (outstanding != '0) & (timer_q == TMR_LAST);
      viol[5] = cyc_q & ~cyc & (outstanding != '0);
      viol[6] = cyc & ack & err;
      if (ALLOW_MIXED == 0) begin
         viol[7] = accept & have_we_q & (we != first_we_q);
      end
   end

   assign new_flags = viol & ~err_flags;

   always_comb begin
      first_idx = '0;
      for (int i = 7; i >= 0; i--) begin
         if (viol[i]) first_idx = 3'(i);
      end
   end

   // Outstanding count saturates at both ends; an orphan response cannot underflow it
   always_comb begin
      out_next = outstanding;
      if (!cyc) begin
         out_next = '0;
      end else if (accept && !resp) begin
         if (outstanding != OUT_MAX) out_next = outstanding + OUT_W'(1);
      end else if (resp && !accept) begin
         if (outstanding != '0) out_next = outstanding - OUT_W'(1);
      end
   end

   always_comb begin
      timer_next = timer_q;
      if (resp || outstanding == '0) begin
         timer_next = '0;
      end else if (timer_q != TMR_MAX) begin
         timer_next = timer_q + TMR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_flags   <= '0;
         err_pulse   <= 1'b0;
         err_first   <= '0;
         err_valid   <= 1'b0;
         outstanding <= '0;
         req_cnt     <= '0;
         rsp_cnt     <= '0;
         timer_q     <= '0;
         cyc_q       <= 1'b0;
         hold_q      <= 1'b0;
         adr_q       <= '0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         dat_q       <= '0;
         have_we_q   <= 1'b0;
         first_we_q  <= 1'b0;
      end else begin
         outstanding <= out_next;
         timer_q     <= timer_next;
         cyc_q       <= cyc;
         hold_q      <= cyc & stb & stall;
         adr_q       <= adr;
         we_q        <= we;
         sel_q       <= sel;
         dat_q       <= dat_m;
         if (!cyc) begin
            have_we_q <= 1'b0;
         end else if (accept && !have_we_q) begin
            have_we_q  <= 1'b1;
            first_we_q <= we;
         end

         if (clear) begin
            err_flags <= '0;
            err_pulse <= 1'b0;
            err_first <= '0;
            err_valid <= 1'b0;
            req_cnt   <= '0;
            rsp_cnt   <= '0;
         end else begin
            err_flags <= err_flags | viol;
            err_pulse <= |new_flags;
            if (!err_valid && (|viol)) begin
               err_first <= first_idx;
               err_valid <= 1'b1;
            end
            if (accept && req_cnt != CNT_MAX) req_cnt <= req_cnt + CNT_WIDTH'(1);
            if (resp && rsp_cnt != CNT_MAX) rsp_cnt <= rsp_cnt + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_wb_protocol_monitor.sv
// Directed bench for wb_protocol_monitor: one task per scenario, inline checks.
module tb_wb_protocol_monitor;

   logic        clk = 1'b0, rst = 1'b1, clear = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, ack = 1'b0, err = 1'b0, stall = 1'b0;
   logic [31:0] adr = '0, dat_m = '0;
   logic [3:0]  sel = 4'hF;

   logic [7:0]  err_flags, m_flags;
   logic        err_pulse, m_pulse, err_valid, m_valid;
   logic [2:0]  err_first, m_first, outstanding, m_out;
   logic [3:0]  req_cnt, rsp_cnt;
   logic [15:0] m_req, m_rsp;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   wb_protocol_monitor #(.MAX_OUTSTANDING(4), .ACK_TIMEOUT(16), .CNT_WIDTH(4), .ALLOW_MIXED(0)) u_dut (
      .clk(clk), .rst(rst), .clear(clear), .cyc(cyc), .stb(stb), .we(we), .adr(adr),
      .sel(sel), .dat_m(dat_m), .ack(ack), .err(err), .stall(stall),
      .err_flags(err_flags), .err_pulse(err_pulse), .err_first(err_first),
      .err_valid(err_valid), .outstanding(outstanding), .req_cnt(req_cnt), .rsp_cnt(rsp_cnt));

   wb_protocol_monitor #(.ALLOW_MIXED(1)) u_mix (
      .clk(clk), .rst(rst), .clear(clear), .cyc(cyc), .stb(stb), .we(we), .adr(adr),
      .sel(sel), .dat_m(dat_m), .ack(ack), .err(err), .stall(stall),
      .err_flags(m_flags), .err_pulse(m_pulse), .err_first(m_first),
      .err_valid(m_valid), .outstanding(m_out), .req_cnt(m_req), .rsp_cnt(m_rsp));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic c, s, w, st, ak, er, input logic [31:0] a);
      cyc = c; stb = s; we = w; stall = st; ack = ak; err = er; adr = a;
   endtask

   task automatic do_clear;
      bus(0, 0, 0, 0, 0, 0, 32'h0);
      clear = 1'b1;
      tick;
      clear = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      n_cmp++;
      if ({err_flags, err_pulse, err_first, err_valid, outstanding, req_cnt, rsp_cnt} !== '0) begin
         n_bad++;
         $display("FAIL reset_state flags=%h pulse=%b first=%0d valid=%b out=%0d req=%0d rsp=%0d, want all 0",
                  err_flags, err_pulse, err_first, err_valid, outstanding, req_cnt, rsp_cnt);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_legal_burst;
      logic [2:0] exp_out [5] = '{3'd1, 3'd2, 3'd2, 3'd1, 3'd0};
      logic       stb_v   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic       ack_v   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      do_clear;
      for (int i = 0; i < 5; i++) begin
         bus(1, stb_v[i], 0, 0, ack_v[i], 0, 32'(i * 4));
         tick;
         n_cmp++;
         if (outstanding !== exp_out[i]) begin
            n_bad++;
            $display("FAIL burst_out[%0d] got %0d want %0d", i, outstanding, exp_out[i]);
         end
      end
      bus(0, 0, 0, 0, 0, 0, 32'h0);
      tick;
      n_cmp++;
      if (err_flags !== 8'h00) begin n_bad++; $display("FAIL burst_flags got %h want 00", err_flags); end
      n_cmp++;
      if (req_cnt !== 4'd3 || rsp_cnt !== 4'd3) begin
         n_bad++;
         $display("FAIL burst_cnt got req=%0d rsp=%0d want 3/3", req_cnt, rsp_cnt);
      end
   endtask

   task automatic test_stall_hold;
      do_clear;
      bus(1, 1, 0, 1, 0, 0, 32'h100);
      tick;
      n_cmp++;
      if (err_flags !== 8'h00) begin n_bad++; $display("FAIL stall_pre got %h want 00", err_flags); end
      adr = 32'h104;
      tick;
      n_cmp++;
      if (err_flags !== 8'h02 || err_pulse !== 1'b1) begin
         n_bad++;
         $display("FAIL stall_flag got flags=%h pulse=%b want 02/1", err_flags, err_pulse);
      end
      n_cmp++;
      if (err_first !== 3'd1 || err_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL stall_first got first=%0d valid=%b want 1/1", err_first, err_valid);
      end
      tick;
      n_cmp++;
      if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL stall_pulse_len got %b want 0", err_pulse); end
      stall = 1'b0;
      tick;
      bus(1, 0, 0, 0, 1, 0, 32'h104);
      tick;
      bus(0, 0, 0, 0, 0, 0, 32'h0);
      tick;
      n_cmp++;
      if (err_flags !== 8'h02 || outstanding !== 3'd0) begin
         n_bad++;
         $display("FAIL stall_after got flags=%h out=%0d want 02/0", err_flags, outstanding);
      end
   endtask

   task automatic test_overflow_orphan;
      do_clear;
      for (int i = 0; i < 5; i++) begin
         bus(1, 1, 0, 0, 0, 0, 32'(i * 4));
         tick;
         n_cmp++;
         if (outstanding !== 3'((i < 4) ? i + 1 : 4)) begin
            n_bad++;
            $display("FAIL ovf_out[%0d] got %0d want %0d", i, outstanding, (i < 4) ? i + 1 : 4);
         end
      end
      n_cmp++;
      if (err_flags !== 8'h08 || err_pulse !== 1'b1 || err_first !== 3'd3) begin
         n_bad++;
         $display("FAIL ovf_flag got flags=%h pulse=%b first=%0d want 08/1/3", err_flags, err_pulse, err_first);
      end
      for (int i = 0; i < 5; i++) begin
         bus(1, 0, 0, 0, 1, 0, 32'h0);
         tick;
         n_cmp++;
         if (outstanding !== 3'((i < 4) ? 3 - i : 0)) begin
            n_bad++;
            $display("FAIL orph_out[%0d] got %0d want %0d", i, outstanding, (i < 4) ? 3 - i : 0);
         end
         n_cmp++;
         if (err_flags !== ((i < 4) ? 8'h08 : 8'h0C)) begin
            n_bad++;
            $display("FAIL orph_flags[%0d] got %h want %h", i, err_flags, (i < 4) ? 8'h08 : 8'h0C);
         end
      end
      bus(0, 0, 0, 0, 0, 0, 32'h0);
      tick;
   endtask

   task automatic test_timeout;
      do_clear;
      bus(1, 1, 0, 0, 0, 0, 32'h40);
      tick;
      bus(1, 0, 0, 0, 0, 0, 32'h0);
      repeat (15) tick;
      n_cmp++;
      if (err_flags !== 8'h00 || outstanding !== 3'd1) begin
         n_bad++;
         $display("FAIL tmo_early got flags=%h out=%0d want 00/1", err_flags, outstanding);
      end
      tick;
      n_cmp++;
      if (err_flags !== 8'h10 || err_pulse !== 1'b1 || err_first !== 3'd4) begin
         n_bad++;
         $display("FAIL tmo_flag got flags=%h pulse=%b first=%0d want 10/1/4", err_flags, err_pulse, err_first);
      end
      clear = 1'b1;
      tick;
      clear = 1'b0;
      repeat (6) tick;
      n_cmp++;
      if (err_flags !== 8'h00) begin n_bad++; $display("FAIL tmo_once got %h want 00", err_flags); end
      bus(1, 0, 0, 0, 1, 0, 32'h0);
      tick;
      n_cmp++;
      if (err_flags !== 8'h00 || outstanding !== 3'd0) begin
         n_bad++;
         $display("FAIL tmo_late_ack got flags=%h out=%0d want 00/0", err_flags, outstanding);
      end
      bus(0, 0, 0, 0, 0, 0, 32'h0);
      tick;
   endtask

   task automatic test_abort_mixed;
      do_clear;
      bus(1, 1, 1, 0, 0, 0, 32'h200);
      tick;
      bus(1, 1, 0, 0, 0, 0, 32'h204);
      tick;
      n_cmp++;
      if (err_flags !== 8'h80 || err_first !== 3'd7 || m_flags !== 8'h00) begin
         n_bad++;
         $display("FAIL mixed got flags=%h first=%0d mix_ok_flags=%h want 80/7/00", err_flags, err_first, m_flags);
      end
      bus(0, 0, 0, 0, 0, 0, 32'h0);
      tick;
      n_cmp++;
      if (err_flags !== 8'hA0 || err_first !== 3'd7 || outstanding !== 3'd0 || err_pulse !== 1'b1) begin
         n_bad++;
         $display("FAIL abort got flags=%h first=%0d out=%0d pulse=%b want A0/7/0/1",
                  err_flags, err_first, outstanding, err_pulse);
      end
      n_cmp++;
      if (m_flags !== 8'h20) begin n_bad++; $display("FAIL abort_mix got %h want 20", m_flags); end
   endtask

   task automatic test_reset_mid;
      do_clear;
      bus(1, 1, 0, 0, 0, 0, 32'h300);
      tick;
      bus(1, 0, 0, 0, 0, 0, 32'h0);
      rst = 1'b1;
      #1;
      n_cmp++;
      if (outstanding !== 3'd0 || req_cnt !== 4'd0) begin
         n_bad++;
         $display("FAIL rst_mid got out=%0d req=%0d want 0/0", outstanding, req_cnt);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      bus(1, 0, 0, 0, 1, 0, 32'h0);
      tick;
      n_cmp++;
      if (err_flags !== 8'h04 || err_first !== 3'd2) begin
         n_bad++;
         $display("FAIL rst_orphan got flags=%h first=%0d want 04/2", err_flags, err_first);
      end
      bus(1, 0, 0, 0, 1, 1, 32'h0);
      tick;
      n_cmp++;
      if (err_flags !== 8'h44 || rsp_cnt !== 4'd2 || err_pulse !== 1'b1) begin
         n_bad++;
         $display("FAIL ack_err got flags=%h rsp=%0d pulse=%b want 44/2/1", err_flags, rsp_cnt, err_pulse);
      end
      bus(0, 0, 0, 0, 0, 0, 32'h0);
      tick;
   endtask

   task automatic test_clear_sat;
      do_clear;
      repeat (20) begin
         bus(1, 1, 0, 0, 0, 0, 32'h10);
         tick;
         bus(1, 0, 0, 0, 1, 0, 32'h0);
         tick;
      end
      n_cmp++;
      if (req_cnt !== 4'd15 || rsp_cnt !== 4'd15 || err_flags !== 8'h00) begin
         n_bad++;
         $display("FAIL sat got req=%0d rsp=%0d flags=%h want 15/15/00", req_cnt, rsp_cnt, err_flags);
      end
      n_cmp++;
      if (m_req !== 16'd20 || m_rsp !== 16'd20) begin
         n_bad++;
         $display("FAIL wide_cnt got req=%0d rsp=%0d want 20/20", m_req, m_rsp);
      end
      bus(0, 0, 0, 0, 0, 0, 32'h0);
      tick;
      bus(1, 0, 0, 0, 1, 0, 32'h0);
      tick;
      n_cmp++;
      if (err_flags !== 8'h04 || err_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL pre_clear got flags=%h valid=%b want 04/1", err_flags, err_valid);
      end
      do_clear;
      n_cmp++;
      if ({err_flags, err_first, err_valid, req_cnt, rsp_cnt} !== '0) begin
         n_bad++;
         $display("FAIL clear got flags=%h first=%0d valid=%b req=%0d rsp=%0d want 0",
                  err_flags, err_first, err_valid, req_cnt, rsp_cnt);
      end
   endtask

   initial begin
      test_reset;
      test_legal_burst;
      test_stall_hold;
      test_overflow_orphan;
      test_timeout;
      test_abort_mixed;
      test_reset_mid;
      test_clear_sat;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
